btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Upstream front-end for the stopwatch board buttons (btnU pause, btnD reset).
- Per button: synchronises the raw pin, debounces it, and classifies activity into single-cycle event pulses: press, release, short click, long hold.
- Drives the top-level enable toggle (click) and counter reset (hold). Replaces the free-running press counter and raw level toggle at top level.
- One instance per button, all in the 100 MHz `clk` domain.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, number of consecutive stable synchronised samples needed to accept a level change (10 ms at 100 MHz); must be >= 2.
- HOLD_CYCLES, 100_000_000, cycles the debounced press must persist to count as a long hold (1 s); must be >= 2.
- REPEAT_CYCLES, 25_000_000, auto-repeat period while held; used only with AUTOREPEAT_EN; must be >= 1.

Ports:
- clk  in  1  100 MHz master clock.
- reset_n  in  1  asynchronous, active-low reset.
- btn_raw  in  1  raw asynchronous button pin, active high.
- btn_level  out  1  debounced button level.
- btn_press  out  1  one-cycle pulse when btn_level rises.
- btn_release  out  1  one-cycle pulse when btn_level falls.
- btn_click  out  1  one-cycle pulse on release when HOLD was not reached (short press).
- btn_hold  out  1  one-cycle pulse when a press reaches HOLD_CYCLES.
- btn_long  out  1  level, high while in HELD state.
- btn_repeat  out  1  auto-repeat pulse train; tied 0 when the feature is compiled out.

Behaviour:
- Reset (async assert, sync release):
  - Sync flops, stable level, all counters and all outputs go to 0.
  - FSM goes to RELEASED.
- Synchroniser:
  - 2 flops, sync1 <= btn_raw, sync2 <= sync1.
- Debounce filter, evaluated each edge:
  - If sync2 == stable: deb_cnt <= 0.
  - Otherwise, if deb_cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and deb_cnt <= 0.
  - Otherwise: deb_cnt <= deb_cnt+1.
  - Any bounce back to the old level clears the count, so no partial credit is kept.
- Latency: if btn_raw is first sampled high at edge 0 and then stays high, btn_level rises after edge DEBOUNCE_CYCLES+1. The same latency applies to a fall.
- Edge pulses:
  - btn_press and btn_release are registered in the same edge that stable changes.
  - Each is exactly 1 cycle wide and aligned with the btn_level transition.
- FSM states: RELEASED, PRESSED, HELD.
  - RELEASED -> PRESSED on a stable rise; hold_cnt <= 0.
  - PRESSED:
    - On a stable fall: -> RELEASED and btn_click pulses.
    - Otherwise, if hold_cnt == HOLD_CYCLES-1: -> HELD and btn_hold pulses.
    - Otherwise: hold_cnt++.
  - HELD -> RELEASED on a stable fall. btn_click does NOT pulse; btn_release does.
  - btn_long = (state == HELD).
- Simultaneous events: a stable fall in the same cycle that hold_cnt reaches HOLD_CYCLES-1 counts as a release. The result is a click, with no hold pulse.
- Counter widths: $clog2 of the respective parameter. Counters never wrap, because each is cleared at its terminal count.
- Reset mid-press: all state is lost. If the button is still down after reset release, it is treated as a fresh press after DEBOUNCE_CYCLES+1 edges.
- No combinational path from btn_raw to any output; every output is registered.

Optional Feature:
- Macro: BTN_CONDITIONER_AUTOREPEAT_EN.
- When defined:
  - In HELD, rep_cnt counts up from 0 starting on the HELD entry edge.
  - btn_repeat pulses 1 cycle each time rep_cnt reaches REPEAT_CYCLES-1, after which rep_cnt clears.
  - The first repeat comes REPEAT_CYCLES cycles after btn_hold.
  - rep_cnt clears on leaving HELD.
  - Purpose: fast minute/second stepping in adjust mode.
- When undefined: no rep_cnt register, and btn_repeat is constant 0.

Decomposition:
- Package btn_pkg:
  - state typedef (RELEASED, PRESSED, HELD, 2-bit).
  - Default constants CLK_HZ = 100_000_000, DEB_10MS, HOLD_1S, REPEAT_250MS.
- Sub-module btn_debounce: synchroniser plus debounce filter; outputs stable, rise and fall.
- FSM, hold logic and repeat logic stay in btn_conditioner.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5.
- Reset: hold reset_n=0 with btn_raw=1 -> all outputs 0. Release reset -> btn_level rises and btn_press pulses after edge 5, counted from the first sampling edge.
- Bounce: btn_raw high 3 cycles, low 1 cycle, then high steady -> exactly one btn_press, 5 edges after the last rising sample; no glitch pulse.
- Short click: press held 10 cycles past btn_press, then clean release -> btn_release and btn_click pulse together, one cycle each; btn_hold never asserts.
- Long hold: press held 30 cycles -> btn_hold pulses exactly 20 cycles after btn_press and btn_long goes high. On release: btn_release pulses, btn_click stays 0, btn_long drops.
- Auto-repeat (macro defined): hold 40 cycles past btn_hold -> btn_repeat pulses at +5, +10, ... cycles after btn_hold. With the macro undefined, btn_repeat stays 0.
- Mid-operation reset: assert reset_n=0 asynchronously while in HELD -> btn_long and all outputs drop immediately without waiting for a clock edge, and the FSM returns to RELEASED.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state type and default timing constants for the button conditioner
package btn_pkg;
  typedef enum logic [1:0] {RELEASED, PRESSED, HELD} btn_state_t;
  localparam int unsigned CLK_HZ       = 100_000_000;
  localparam int unsigned DEB_10MS     = CLK_HZ / 100;
  localparam int unsigned HOLD_1S      = CLK_HZ;
  localparam int unsigned REPEAT_250MS = CLK_HZ / 4;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser plus consecutive-sample debounce filter
// Ports: clk, reset_n (async active-low), btn_raw (raw pin), stable (debounced level),
//        rise/fall (strobes high in the cycle whose closing edge changes stable)
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEB_10MS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic stable,
  output logic rise,
  output logic fall
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  logic sync1, sync2, accept;
  logic [DW-1:0] deb_cnt;
  always_comb begin
    accept = sync2 != stable && deb_cnt == DW'(DEBOUNCE_CYCLES - 1);
    rise = accept & sync2;
    fall = accept & ~sync2;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      stable  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      deb_cnt <= (sync2 == stable || accept) ? '0 : deb_cnt + 1'b1;
      stable  <= accept ? sync2 : stable;
    end
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: debounced button with press/release/click/hold event pulses
// Ports: clk, reset_n (async active-low), btn_raw (raw pin, active high),
//        btn_level, btn_press, btn_release, btn_click, btn_hold, btn_long, btn_repeat
// Macro BTN_CONDITIONER_AUTOREPEAT_EN enables the btn_repeat pulse train while held.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEB_10MS,
  parameter int unsigned HOLD_CYCLES     = HOLD_1S,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_250MS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_click,
  output logic btn_hold,
  output logic btn_long,
  output logic btn_repeat
);
  localparam int HW = $clog2(HOLD_CYCLES);
  logic rise, fall;
  btn_state_t state;
  logic [HW-1:0] hold_cnt;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_raw(btn_raw),
    .stable (btn_level),
    .rise   (rise),
    .fall   (fall)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= RELEASED;
      hold_cnt    <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_click   <= 1'b0;
      btn_hold    <= 1'b0;
      btn_long    <= 1'b0;
    end else begin
      btn_press   <= rise;
      btn_release <= fall;
      btn_click   <= 1'b0;
      btn_hold    <= 1'b0;
      case (state)
        RELEASED: if (rise) begin
          state    <= PRESSED;
          hold_cnt <= '0;
        end
        PRESSED: if (fall) begin
          state     <= RELEASED;
          btn_click <= 1'b1;
        end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          state    <= HELD;
          btn_hold <= 1'b1;
          btn_long <= 1'b1;
        end else hold_cnt <= hold_cnt + 1'b1;
        HELD: if (fall) begin
          state    <= RELEASED;
          btn_long <= 1'b0;
        end
        default: state <= RELEASED;
      endcase
    end
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
  localparam int RW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
  logic [RW-1:0] rep_cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rep_cnt    <= '0;
      btn_repeat <= 1'b0;
    end else begin
      btn_repeat <= 1'b0;
      if (state != HELD || fall) rep_cnt <= '0;
      else if (rep_cnt == RW'(REPEAT_CYCLES - 1)) begin
        rep_cnt    <= '0;
        btn_repeat <= 1'b1;
      end else rep_cnt <= rep_cnt + 1'b1;
    end
`else
  assign btn_repeat = 1'b0 && REPEAT_CYCLES == 0;
`endif
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed plus random button stimulus checked against a timestamp-based model
module tb_btn_conditioner;
  localparam int D = 4, H = 20, R = 5;
  logic clk = 1'b0, reset_n = 1'b0, btn_raw = 1'b0;
  logic btn_level, btn_press, btn_release, btn_click, btn_hold, btn_long, btn_repeat;
  int total = 0, bad = 0;
  int n = 0, p = 0, run = 0;
  logic h1 = 1'b0, h2 = 1'b0, m_lvl = 1'b0;
  always #5 clk = ~clk;
  btn_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_click  (btn_click),
    .btn_hold   (btn_hold),
    .btn_long   (btn_long),
    .btn_repeat (btn_repeat)
  );
  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%b want=%b", tag, n, obs, exp);
    end
  endtask
  task automatic step(input logic raw);
    logic s, rose, fell, e_rep;
    @(negedge clk);
    btn_raw = raw;
    @(posedge clk);
    s  = h2;
    h2 = h1;
    h1 = raw;
    run = (s != m_lvl) ? run + 1 : 0;
    rose = 1'b0;
    fell = 1'b0;
    if (run == D) begin
      run   = 0;
      m_lvl = s;
      rose  = s;
      fell  = !s;
    end
    n++;
    if (rose) p = n;
    e_rep = 1'b0;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    e_rep = m_lvl && n - p > H && (n - p - H) % R == 0;
`endif
    #1;
    chk("level", btn_level, m_lvl);
    chk("press", btn_press, rose);
    chk("release", btn_release, fell);
    chk("click", btn_click, fell && n - p <= H);
    chk("hold", btn_hold, m_lvl && n - p == H);
    chk("long", btn_long, m_lvl && n - p >= H);
    chk("repeat", btn_repeat, e_rep);
  endtask
  task automatic do_reset(input logic raw);
    @(posedge clk);
    #3 btn_raw = raw;
    reset_n = 1'b0;
    #1;
    chk("rst_level", btn_level, 1'b0);
    chk("rst_press", btn_press, 1'b0);
    chk("rst_release", btn_release, 1'b0);
    chk("rst_click", btn_click, 1'b0);
    chk("rst_hold", btn_hold, 1'b0);
    chk("rst_long", btn_long, 1'b0);
    chk("rst_repeat", btn_repeat, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("rst_level_held", btn_level, 1'b0);
    #1 reset_n = 1'b1;
    h1 = 1'b0;
    h2 = 1'b0;
    m_lvl = 1'b0;
    run = 0;
  endtask
  initial begin
    do_reset(1'b1);
    repeat (10) step(1'b1);
    repeat (10) step(1'b0);
    repeat (3) step(1'b1);
    step(1'b0);
    repeat (15) step(1'b1);
    repeat (8) step(1'b0);
    repeat (16) step(1'b1);
    repeat (10) step(1'b0);
    repeat (36) step(1'b1);
    repeat (10) step(1'b0);
    repeat (66) step(1'b1);
    chk("long_before_rst", btn_long, 1'b1);
    do_reset(1'b1);
    repeat (10) step(1'b1);
    repeat (10) step(1'b0);
    for (int i = 0; i < 300; i++) begin
      logic lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 40);
      for (int j = 0; j < len; j++) step($urandom_range(0, 9) == 0 ? !lvl : lvl);
      if ($urandom_range(0, 49) == 0) do_reset(lvl);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
